// File: rtl/toggle_seq_ctrl.sv
// -----------------------------------------------------------------------------
// toggle_seq_ctrl
//   Modulo-M up/down counter built as a toggle-flop sequencer. Q advances by
//   XOR-ing in the toggle vector T, which is the combinational difference
//   between the current count and its successor. A four-state controller
//   (IDLE/RUN/HOLD/DONE) gates counting, loading and one-shot termination.
//
// Parameters
//   WIDTH    counter / toggle-vector width (2..16)
//   ONESHOT  0: wrap continuously, 1: enter DONE on the first wrap
//
// Ports
//   clk       in   clock, rising edge
//   clr       in   synchronous active-low clear
//   start     in   begin / resume counting (level)
//   stop      in   pause counting (level)
//   up        in   direction, 1 = up, 0 = down
//   load      in   load Q from load_val (ignored while RUN)
//   load_val  in   value to load, clamped to M-1
//   mod_n     in   modulus, 0 means 2^WIDTH
//   T         out  toggle enables for this cycle (combinational)
//   Q         out  registered count
//   Qn        out  ~Q
//   busy      out  state is RUN
//   tc        out  terminal count in the current direction while RUN
//   done      out  state is DONE
// -----------------------------------------------------------------------------
module toggle_seq_ctrl #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned ONESHOT = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             stop,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] mod_n,
  output logic [WIDTH-1:0] T,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  localparam bit ONESHOT_EN = (ONESHOT != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Declaration initialisers give a defined IDLE / zero count at time zero.
  state_e           state_q = S_IDLE;
  state_e           state_d;
  logic [WIDTH-1:0] q_q = '0;
  logic [WIDTH-1:0] q_d;

  logic [WIDTH-1:0] m_max;         // M-1, the largest legal count
  logic [WIDTH-1:0] q_step;        // successor of q_q in the current direction
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] t_c;
  logic             run;
  logic             wrap;
  logic             tc_c;

  // Effective modulus minus one; mod_n == 0 selects the full 2^WIDTH range.
  always_comb begin
    m_max = '1;
    if (mod_n != '0) begin
      m_max = mod_n - WIDTH'(1);
    end
  end

  // Successor value. A count left above M-1 by a modulus change wraps to 0
  // when counting up and simply decrements when counting down.
  always_comb begin
    q_step = '0;
    wrap   = 1'b0;
    if (up) begin
      if (q_q >= m_max) begin
        q_step = '0;
        wrap   = 1'b1;
      end else begin
        q_step = q_q + WIDTH'(1);
      end
    end else begin
      if (q_q == '0) begin
        q_step = m_max;
        wrap   = 1'b1;
      end else begin
        q_step = q_q - WIDTH'(1);
      end
    end
  end

  // Loads saturate at M-1.
  always_comb begin
    load_clamped = load_val;
    if (load_val > m_max) begin
      load_clamped = m_max;
    end
  end

  assign run = (state_q == S_RUN);

  // Toggle vector; masked while clr is low so T never announces a flip that
  // the clear is about to suppress.
  always_comb begin
    t_c = '0;
    if (run && clr) begin
      t_c = q_q ^ q_step;
    end
  end

  always_comb begin
    tc_c = 1'b0;
    if (run) begin
      tc_c = up ? (q_q == m_max) : (q_q == '0);
    end
  end

  // Next-state and next-count decode. Priority: load, then stop, then start.
  always_comb begin
    state_d = state_q;
    q_d     = q_q ^ t_c;
    unique case (state_q)
      S_RUN: begin
        // load is ignored while counting; the step is taken on this edge.
        if (stop) begin
          state_d = S_HOLD;
        end else if (ONESHOT_EN && wrap) begin
          state_d = S_DONE;
        end
      end
      S_IDLE, S_HOLD, S_DONE: begin
        if (load) begin
          q_d = load_clamped;
          if (state_q == S_DONE) begin
            state_d = S_HOLD;
          end
        end else if (start && !stop) begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and count registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= S_IDLE;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
    end
  end

  assign T    = t_c;
  assign Q    = q_q;
  assign Qn   = ~q_q;
  assign busy = run;
  assign tc   = tc_c;
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_toggle_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_toggle_seq_ctrl
//   Two instances (continuous and one-shot) share one stimulus stream and are
//   compared every cycle against an integer reference model, followed by a
//   long randomized run. Directed scenarios add spot checks on literal values.
// -----------------------------------------------------------------------------
module tb_toggle_seq_ctrl;

  localparam int unsigned WIDTH = 4;
  localparam int          FULL  = 1 << WIDTH;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HOLD = 2;
  localparam int M_DONE = 3;

  logic             clk;
  logic             clr;
  logic             start;
  logic             stop;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] mod_n;

  logic [WIDTH-1:0] dt   [2];
  logic [WIDTH-1:0] dq   [2];
  logic [WIDTH-1:0] dqn  [2];
  logic             dbusy[2];
  logic             dtc  [2];
  logic             ddone[2];

  int n_checks;
  int n_fail;

  // Reference model: abstract mode and integer count per instance.
  int mst[2];
  int mq [2];
  bit mos[2];

  toggle_seq_ctrl #(.WIDTH(WIDTH), .ONESHOT(0)) u_cont (
    .clk(clk), .clr(clr), .start(start), .stop(stop), .up(up), .load(load),
    .load_val(load_val), .mod_n(mod_n),
    .T(dt[0]), .Q(dq[0]), .Qn(dqn[0]), .busy(dbusy[0]), .tc(dtc[0]), .done(ddone[0])
  );

  toggle_seq_ctrl #(.WIDTH(WIDTH), .ONESHOT(1)) u_once (
    .clk(clk), .clr(clr), .start(start), .stop(stop), .up(up), .load(load),
    .load_val(load_val), .mod_n(mod_n),
    .T(dt[1]), .Q(dq[1]), .Qn(dqn[1]), .busy(dbusy[1]), .tc(dtc[1]), .done(ddone[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  function automatic int m_eff(input logic [WIDTH-1:0] mn);
    return (mn == '0) ? FULL : int'(mn);
  endfunction

  function automatic int next_count(input int q, input int m, input logic u);
    if (u) return (q >= m - 1) ? 0 : q + 1;
    return (q == 0) ? m - 1 : q - 1;
  endfunction

  // Compare every output of both instances against the model's current view.
  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      int m;
      int exp_t;
      int exp_tc;
      m      = m_eff(mod_n);
      exp_t  = (mst[i] == M_RUN && clr) ? (mq[i] ^ next_count(mq[i], m, up)) : 0;
      exp_tc = (mst[i] == M_RUN) && (up ? (mq[i] == m - 1) : (mq[i] == 0));
      chk($sformatf("Q[%0d]", i),    32'(dq[i]),    32'(mq[i]));
      chk($sformatf("Qn[%0d]", i),   32'(dqn[i]),   32'((FULL - 1) ^ mq[i]));
      chk($sformatf("T[%0d]", i),    32'(dt[i]),    32'(exp_t));
      chk($sformatf("busy[%0d]", i), 32'(dbusy[i]), 32'(mst[i] == M_RUN));
      chk($sformatf("tc[%0d]", i),   32'(dtc[i]),   32'(exp_tc));
      chk($sformatf("done[%0d]", i), 32'(ddone[i]), 32'(mst[i] == M_DONE));
    end
  endtask

  // Advance the model by one clock edge using the inputs held across it.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int m;
      int nq;
      bit wrapped;
      m = m_eff(mod_n);
      if (!clr) begin
        mst[i] = M_IDLE;
        mq[i]  = 0;
      end else if (mst[i] == M_RUN) begin
        nq      = next_count(mq[i], m, up);
        wrapped = up ? (nq == 0) : (mq[i] == 0);
        mq[i]   = nq;
        if (stop)                    mst[i] = M_HOLD;
        else if (mos[i] && wrapped)  mst[i] = M_DONE;
      end else if (load) begin
        mq[i] = (int'(load_val) >= m) ? m - 1 : int'(load_val);
        if (mst[i] == M_DONE) mst[i] = M_HOLD;
      end else if (start && !stop) begin
        mst[i] = M_RUN;
      end
    end
  endtask

  // One clock: drive at negedge, check before the rising edge, then step model.
  task automatic cyc(input logic c, input logic s, input logic p, input logic u,
                     input logic l, input logic [WIDTH-1:0] lv, input logic [WIDTH-1:0] mn);
    @(negedge clk);
    clr = c; start = s; stop = p; up = u; load = l; load_val = lv; mod_n = mn;
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] frozen;
    logic             r_up;
    logic [WIDTH-1:0] r_mod;

    n_checks = 0;
    n_fail   = 0;
    mos[0] = 1'b0;
    mos[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mst[i] = M_IDLE;
      mq[i]  = 0;
    end
    clr = 1'b0; start = 1'b0; stop = 1'b0; up = 1'b1; load = 1'b0;
    load_val = '0; mod_n = 4'd10;

    // Power-on values before any edge.
    #1;
    check_all();

    // V1: up count modulo 10.
    cyc(0, 0, 0, 1, 0, 0, 10);
    cyc(1, 1, 0, 1, 0, 0, 10);
    chk("v1_busy", 32'(dbusy[0]), 32'd1);
    chk("v1_q0",   32'(dq[0]),    32'd0);
    for (int k = 1; k <= 10; k++) begin
      cyc(1, 0, 0, 1, 0, 0, 10);
      chk("v1_seq", 32'(dq[0]), 32'(k % 10));
      if (k == 7) chk("v1_t78", 32'(dt[0]), 32'hF);
      if (k == 9) chk("v1_tc9", 32'(dtc[0]), 32'd1);
    end

    // V2: load 2 in IDLE, count down modulo 10.
    cyc(0, 0, 0, 0, 0, 0, 10);
    cyc(1, 0, 0, 0, 1, 2, 10);
    chk("v2_load", 32'(dq[0]), 32'd2);
    cyc(1, 1, 0, 0, 0, 0, 10);
    cyc(1, 0, 0, 0, 0, 0, 10);
    chk("v2_q1", 32'(dq[0]), 32'd1);
    cyc(1, 0, 0, 0, 0, 0, 10);
    chk("v2_q0", 32'(dq[0]), 32'd0);
    chk("v2_tc0", 32'(dtc[0]), 32'd1);
    cyc(1, 0, 0, 0, 0, 0, 10);
    chk("v2_q9", 32'(dq[0]), 32'd9);
    cyc(1, 0, 0, 0, 0, 0, 10);
    chk("v2_q8", 32'(dq[0]), 32'd8);

    // V3: pause with start+stop, resume with start.
    cyc(0, 0, 0, 1, 0, 0, 10);
    cyc(1, 1, 0, 1, 0, 0, 10);
    for (int k = 0; k < 3; k++) cyc(1, 0, 0, 1, 0, 0, 10);
    cyc(1, 1, 1, 1, 0, 0, 10);
    frozen = dq[0];
    chk("v3_hold_busy", 32'(dbusy[0]), 32'd0);
    chk("v3_frozen_val", 32'(frozen), 32'd4);
    cyc(1, 0, 0, 1, 0, 0, 10);
    chk("v3_frozen", 32'(dq[0]), 32'(frozen));
    chk("v3_t0",     32'(dt[0]), 32'd0);
    cyc(1, 1, 0, 1, 0, 0, 10);
    chk("v3_resume_q", 32'(dq[0]), 32'(frozen));
    cyc(1, 0, 0, 1, 0, 0, 10);
    chk("v3_step", 32'(dq[0]), 32'(frozen + 1));

    // V4: load clamps to M-1.
    cyc(0, 0, 0, 1, 0, 0, 6);
    cyc(1, 0, 0, 1, 1, 13, 6);
    chk("v4_clamp", 32'(dq[0]), 32'd5);

    // V5: one-shot, full range.
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(1, 1, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      cyc(1, 0, 0, 1, 0, 0, 0);
      chk("v5_seq", 32'(dq[1]), 32'(k % 16));
    end
    chk("v5_done", 32'(ddone[1]), 32'd1);
    chk("v5_busy", 32'(dbusy[1]), 32'd0);
    chk("v5_t",    32'(dt[1]),    32'd0);
    cyc(1, 1, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 0, 0);
    chk("v5_restart", 32'(dq[1]), 32'd1);

    // V6: clear in the middle of a run.
    cyc(0, 0, 0, 1, 0, 0, 10);
    cyc(1, 1, 0, 1, 0, 0, 10);
    for (int k = 0; k < 7; k++) cyc(1, 0, 0, 1, 0, 0, 10);
    chk("v6_q7", 32'(dq[0]), 32'd7);
    cyc(0, 0, 0, 1, 0, 0, 10);
    chk("v6_q",    32'(dq[0]),    32'd0);
    chk("v6_qn",   32'(dqn[0]),   32'hF);
    chk("v6_busy", 32'(dbusy[0]), 32'd0);
    cyc(0, 1, 0, 1, 0, 0, 10);
    chk("v6_held", 32'(dbusy[0]), 32'd0);

    // Randomized run against the model.
    r_up  = 1'b1;
    r_mod = 4'd10;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 9) == 0)  r_up  = ~r_up;
      if ($urandom_range(0, 49) == 0) r_mod = WIDTH'($urandom_range(0, FULL - 1));
      cyc($urandom_range(0, 59) != 0,
          $urandom_range(0, 2) == 0,
          $urandom_range(0, 7) == 0,
          r_up,
          $urandom_range(0, 9) == 0,
          WIDTH'($urandom_range(0, FULL - 1)),
          r_mod);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
